// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: bounded coin credit, per-item prices, greedy coin-by-coin change.
// Define VEND_STOCK_EN to build per-item stock counters with sold-out flags and restock.
module vending_machine_multi #(
    parameter int NUM_ITEMS = 4,
    parameter int BAL_W = 8,
    parameter logic [NUM_ITEMS*BAL_W-1:0] PRICES = {8'd100, 8'd75, 8'd50, 8'd25},
    parameter int MAX_BALANCE = 200,
    parameter int STOCK_W = 4,
    parameter int STOCK_INIT = 3,
    localparam int ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_coin_5,
    input  logic                 in_coin_10,
    input  logic                 in_coin_25,
    input  logic                 sel_valid,
    input  logic [ITEM_W-1:0]    sel_item,
    input  logic                 cancel,
    input  logic                 restock,
    input  logic                 coin_out_ready,
    output logic                 product_dispense,
    output logic [ITEM_W-1:0]    dispense_item,
    output logic                 coin_out_valid,
    output logic [BAL_W-1:0]     coin_out_value,
    output logic [BAL_W-1:0]     change_out,
    output logic [BAL_W-1:0]     current_balance,
    output logic                 coin_reject,
    output logic                 sel_error,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VEND,
        S_CHANGE
    } state_t;

    localparam logic [BAL_W:0] MAX_SUM = (BAL_W+1)'(MAX_BALANCE);

    state_t               state_q;
    logic [BAL_W-1:0]     bal_q;
    logic [BAL_W-1:0]     change_q;
    logic [BAL_W-1:0]     coin_value_q;
    logic [ITEM_W-1:0]    item_q;
    logic                 dispense_q;
    logic                 coin_valid_q;
    logic                 reject_q;
    logic                 sel_err_q;
    logic                 busy_q;
    logic [NUM_ITEMS-1:0] sold_w;

    logic [2:0]           coins;
    logic                 coin_any;
    logic                 coin_one;
    logic [BAL_W:0]       coin_amt_d;
    logic [BAL_W:0]       coin_sum_d;
    logic                 coin_fits_d;
    logic                 sel_in_range_d;
    logic                 sel_sold_d;
    logic                 sel_ok_d;
    logic [BAL_W-1:0]     sel_price_d;
    logic [BAL_W-1:0]     vend_rem_d;
    logic [BAL_W-1:0]     pay_rem_d;

    function automatic logic [BAL_W-1:0] price_of(input logic [ITEM_W-1:0] idx);
        logic [BAL_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (idx == ITEM_W'(i)) p = PRICES[i*BAL_W +: BAL_W];
        end
        return p;
    endfunction

    // Largest hopper coin not exceeding the amount still owed.
    function automatic logic [BAL_W-1:0] next_coin(input logic [BAL_W-1:0] amount);
        logic [BAL_W-1:0] c;
        if (amount >= BAL_W'(25))      c = BAL_W'(25);
        else if (amount >= BAL_W'(10)) c = BAL_W'(10);
        else                           c = BAL_W'(5);
        return c;
    endfunction

    assign coins    = {in_coin_25, in_coin_10, in_coin_5};
    assign coin_any = |coins;
    assign coin_one = $onehot(coins);

    always_comb begin
        coin_amt_d = '0;
        if (in_coin_25)      coin_amt_d = (BAL_W+1)'(25);
        else if (in_coin_10) coin_amt_d = (BAL_W+1)'(10);
        else if (in_coin_5)  coin_amt_d = (BAL_W+1)'(5);
    end

    assign coin_sum_d     = {1'b0, bal_q} + coin_amt_d;
    assign coin_fits_d    = coin_one && (coin_sum_d <= MAX_SUM);
    assign sel_price_d    = price_of(sel_item);
    assign sel_in_range_d = ({1'b0, sel_item} < (ITEM_W+1)'(NUM_ITEMS));

    always_comb begin
        sel_sold_d = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_item == ITEM_W'(i)) sel_sold_d = sold_w[i];
        end
    end

    // Price is checked against the balance before any same-cycle coin.
    assign sel_ok_d   = sel_in_range_d && (bal_q >= sel_price_d) && !sel_sold_d;
    assign vend_rem_d = bal_q - price_of(item_q);
    assign pay_rem_d  = bal_q - coin_value_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bal_q        <= '0;
            change_q     <= '0;
            coin_value_q <= '0;
            item_q       <= '0;
            dispense_q   <= 1'b0;
            coin_valid_q <= 1'b0;
            reject_q     <= 1'b0;
            sel_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            dispense_q <= 1'b0;
            reject_q   <= coin_any;
            sel_err_q  <= sel_valid;
            case (state_q)
                S_IDLE: begin
                    if (cancel && (bal_q != '0)) begin
                        // Coins arriving with the cancel are handed back so the refund matches change_out.
                        sel_err_q    <= 1'b0;
                        change_q     <= bal_q;
                        coin_valid_q <= 1'b1;
                        coin_value_q <= next_coin(bal_q);
                        busy_q       <= 1'b1;
                        state_q      <= S_CHANGE;
                    end else begin
                        reject_q  <= coin_any && !coin_fits_d;
                        sel_err_q <= sel_valid && !sel_ok_d;
                        if (coin_fits_d) bal_q <= coin_sum_d[BAL_W-1:0];
                        if (sel_valid && sel_ok_d) begin
                            item_q     <= sel_item;
                            dispense_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= S_VEND;
                        end
                    end
                end
                S_VEND: begin
                    bal_q    <= vend_rem_d;
                    change_q <= vend_rem_d;
                    if (vend_rem_d != '0) begin
                        coin_valid_q <= 1'b1;
                        coin_value_q <= next_coin(vend_rem_d);
                        state_q      <= S_CHANGE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_CHANGE: begin
                    if (coin_out_ready) begin
                        bal_q <= pay_rem_d;
                        if (pay_rem_d == '0) begin
                            coin_valid_q <= 1'b0;
                            coin_value_q <= '0;
                            busy_q       <= 1'b0;
                            state_q      <= S_IDLE;
                        end else begin
                            coin_value_q <= next_coin(pay_rem_d);
                        end
                    end
                end
                default: begin
                    coin_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];

    // Restock overrides a dispense decrement landing on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (rst || restock) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end else if ((state_q == S_VEND) && (item_q == ITEM_W'(i)) && (stock_q[i] != '0)) begin
                stock_q[i] <= stock_q[i] - STOCK_W'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            sold_w[i] = (stock_q[i] == '0);
        end
    end
`else
    logic unused_stock_cfg;
    assign unused_stock_cfg = restock ^ (STOCK_W > 0) ^ (STOCK_INIT > 0);
    assign sold_w = '0;
`endif

    assign product_dispense = dispense_q;
    assign dispense_item    = item_q;
    assign coin_out_valid   = coin_valid_q;
    assign coin_out_value   = coin_value_q;
    assign change_out       = change_q;
    assign current_balance  = bal_q;
    assign coin_reject      = reject_q;
    assign sel_error        = sel_err_q;
    assign sold_out         = sold_w;
    assign busy             = busy_q;

endmodule
